// File: rtl/arith_flag_unit_if.sv
// rtl/arith_flag_unit_if.sv - arithbox result / flag update and condition query bundle
interface arith_flag_unit_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  arithop;
  logic [3:0]  calc_sz;
  logic [31:0] resa;
  logic        co;
  logic        af;
  logic        sa;
  logic        sb;
  logic        cmp;
  logic [5:0]  flg_mask;
  logic        cc_valid;
  logic [3:0]  cc_code;
  logic        cc_ready;
  logic        cc_done;
  logic        cc_taken;
  logic        ci;
  logic        ai;

  modport master (
    output upd_valid, arithop, calc_sz, resa, co, af, sa, sb, cmp, flg_mask,
    output cc_valid, cc_code,
    input  upd_ready, cc_ready, cc_done, cc_taken, ci, ai
  );

  modport slave (
    input  upd_valid, arithop, calc_sz, resa, co, af, sa, sb, cmp, flg_mask,
    input  cc_valid, cc_code,
    output upd_ready, cc_ready, cc_done, cc_taken, ci, ai
  );
endinterface

// File: rtl/arith_flag_unit.sv
// rtl/arith_flag_unit.sv - EFLAGS derivation/commit from arithbox results plus Jcc/SETcc evaluation
module arith_flag_unit #(
  parameter logic [15:0] RST_FLAGS = 16'h0002
) (
  input  logic              clk,
  input  logic              rstn,
  arith_flag_unit_if.slave  bus,
  input  logic              wr_en,
  input  logic [15:0]       wr_data,
  output logic              res_we,
  output logic [15:0]       eflags
);

  typedef enum logic [1:0] {IDLE, CAP, CMT} state_t;

  state_t      state_q;
  logic [3:0]  op_q;
  logic [3:0]  sz_q;
  logic [31:0] resa_q;
  logic        co_q, af_q, sa_q, sb_q, cmp_q;
  logic [5:0]  mask_q;
  logic [5:0]  flags_q;
  logic [5:0]  flags_d;
  logic        opok_q;
  logic        res_we_q;
  logic [15:0] eflags_q;
  logic [15:0] eflags_cmt;
  logic        cc_done_q, cc_taken_q;
  logic        cc_hit;

  // flags_d layout matches flg_mask: {OF,SF,ZF,AF,PF,CF}
  always_comb begin
    logic msb, zf, pf, cf, of, logic_op;
    logic_op = (op_q == 4'b0001) || (op_q == 4'b0100) || (op_q == 4'b0110);
    if (sz_q == 4'd4) begin
      msb = resa_q[31];
      zf  = (resa_q == 32'd0);
    end else if (sz_q == 4'd2) begin
      msb = resa_q[15];
      zf  = (resa_q[15:0] == 16'd0);
    end else begin
      msb = resa_q[7];
      zf  = (resa_q[7:0] == 8'd0);
    end
    pf = ~^resa_q[7:0];
    cf = logic_op ? 1'b0 : co_q;
    of = logic_op ? 1'b0 : ((sa_q == sb_q) && (msb != sa_q));
    flags_d = {of, msb, zf, af_q, pf, cf};
  end

  always_comb begin
    logic [5:0] m;
    m          = mask_q & {6{opok_q}};
    eflags_cmt = eflags_q;
    if (m[0]) eflags_cmt[0]  = flags_q[0];
    if (m[1]) eflags_cmt[2]  = flags_q[1];
    if (m[2]) eflags_cmt[4]  = flags_q[2];
    if (m[3]) eflags_cmt[6]  = flags_q[3];
    if (m[4]) eflags_cmt[7]  = flags_q[4];
    if (m[5]) eflags_cmt[11] = flags_q[5];
  end

  always_comb begin
    logic base;
    case (bus.cc_code[3:1])
      3'd0:    base = eflags_q[11];
      3'd1:    base = eflags_q[0];
      3'd2:    base = eflags_q[6];
      3'd3:    base = eflags_q[0] | eflags_q[6];
      3'd4:    base = eflags_q[7];
      3'd5:    base = eflags_q[2];
      3'd6:    base = eflags_q[7] ^ eflags_q[11];
      default: base = eflags_q[6] | (eflags_q[7] ^ eflags_q[11]);
    endcase
    cc_hit = base ^ bus.cc_code[0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      op_q       <= 4'd0;
      sz_q       <= 4'd0;
      resa_q     <= 32'd0;
      co_q       <= 1'b0;
      af_q       <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      cmp_q      <= 1'b0;
      mask_q     <= 6'd0;
      flags_q    <= 6'd0;
      opok_q     <= 1'b0;
      res_we_q   <= 1'b0;
      eflags_q   <= RST_FLAGS;
      cc_done_q  <= 1'b0;
      cc_taken_q <= 1'b0;
    end else begin
      cc_done_q <= 1'b0;
      res_we_q  <= 1'b0;
      if (bus.cc_valid && state_q == IDLE) begin
        cc_done_q  <= 1'b1;
        cc_taken_q <= cc_hit;
      end
      case (state_q)
        IDLE: begin
          if (bus.upd_valid) begin
            op_q    <= bus.arithop;
            sz_q    <= bus.calc_sz;
            resa_q  <= bus.resa;
            co_q    <= bus.co;
            af_q    <= bus.af;
            sa_q    <= bus.sa;
            sb_q    <= bus.sb;
            cmp_q   <= bus.cmp;
            mask_q  <= bus.flg_mask;
            state_q <= CAP;
          end
        end
        CAP: begin
          if (wr_en) begin
            state_q <= IDLE;
          end else begin
            flags_q  <= flags_d;
            opok_q   <= ~op_q[3];
            res_we_q <= ~cmp_q;
            state_q  <= CMT;
          end
        end
        default: begin
          state_q <= IDLE;
          if (!wr_en) eflags_q <= eflags_cmt;
        end
      endcase
      // Direct writes are ordered last so they override a same-cycle commit.
      if (wr_en) eflags_q <= wr_data | 16'h0002;
    end
  end

  // A direct write landing in the commit cycle cancels the writeback strobe too.
  assign res_we        = res_we_q & ~wr_en;
  assign eflags        = eflags_q;
  assign bus.upd_ready = (state_q == IDLE);
  assign bus.cc_ready  = (state_q == IDLE);
  assign bus.cc_done   = cc_done_q;
  assign bus.cc_taken  = cc_taken_q;
  assign bus.ci        = eflags_q[0];
  assign bus.ai        = eflags_q[4];

endmodule
